// File: rtl/nvme_mc_fifo.sv
// nvme_mc_fifo: several logical FIFOs sharing one RAM. A round-robin arbiter
// drains non-empty channels through a RAM read register (S1) into a registered
// valid/ack output stage (S2) that tags each word with its source channel.
module nvme_mc_fifo #(
  parameter int width             = 8,
  parameter int awidth            = 4,
  parameter int channels          = 2,
  parameter int chwidth           = 1,
  parameter int almost_full_count = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           write,
  input  logic [chwidth-1:0]             wch,
  input  logic [width-1:0]               wdata,
  output logic [channels-1:0]            wfull,
  output logic [channels-1:0]            wafull,
  output logic                           werr,
  output logic [channels*(awidth+1)-1:0] count,
  input  logic                           rack,
  output logic                           rval,
  output logic [width-1:0]               rdata,
  output logic [chwidth-1:0]             rch
);

  localparam int depth = 1 << awidth;
  localparam logic [awidth:0]   cnt_full = (awidth+1)'(depth);
  localparam logic [awidth:0]   cnt_one  = (awidth+1)'(1);
  localparam logic [awidth-1:0] ptr_one  = awidth'(1);
  localparam logic              af_reset = (almost_full_count >= depth);

  // Shared storage: channel c owns addresses {c, ptr}
  logic [width-1:0] mem [channels*depth];

  // Per-channel bookkeeping
  logic [awidth:0]   count_q [channels];
  logic [awidth:0]   count_d [channels];
  logic [awidth-1:0] wptr_q  [channels];
  logic [awidth-1:0] wptr_d  [channels];
  logic [awidth-1:0] rptr_q  [channels];
  logic [awidth-1:0] rptr_d  [channels];
  logic [channels-1:0] wfull_q, wfull_d;
  logic [channels-1:0] wafull_q, wafull_d;
  logic werr_q, werr_d;
  logic [chwidth-1:0] rr_ptr_q, rr_ptr_d;

  // Read pipeline registers
  logic               s1_v_q, s1_v_d;
  logic [chwidth-1:0] s1_ch_q, s1_ch_d;
  logic [width-1:0]   s1_data_q;
  logic               rval_q, rval_d;
  logic [width-1:0]   rdata_q, rdata_d;
  logic [chwidth-1:0] rch_q, rch_d;

  // Combinational control
  logic                      wch_ok;
  logic                      wr_en;
  logic [chwidth+awidth-1:0] waddr;
  logic [chwidth+awidth-1:0] raddr;
  logic                      s1_ready;
  logic                      s2_ready;
  logic                      found;
  logic                      grant_v;
  logic [chwidth-1:0]        grant_ch;
  logic [chwidth-1:0]        cand;

  // Write acceptance: drop writes to full or nonexistent channels
  always_comb begin
    wch_ok = 32'(wch) < 32'(channels);
    wr_en  = write && wch_ok && !wfull_q[wch];
    werr_d = write && !wr_en;
    waddr  = {wch, wptr_q[wch]};
  end

  // Handshake readiness and round-robin grant starting at rr_ptr
  always_comb begin
    s2_ready = !rval_q || rack;
    s1_ready = !s1_v_q || s2_ready;
    found    = 1'b0;
    grant_ch = rr_ptr_q;
    cand     = '0;
    for (int i = 0; i < channels; i++) begin
      cand = chwidth'((32'(rr_ptr_q) + 32'(i)) % 32'(channels));
      if (!found && count_q[cand] != '0) begin
        found    = 1'b1;
        grant_ch = cand;
      end
    end
    grant_v  = found && s1_ready;
    raddr    = {grant_ch, rptr_q[grant_ch]};
    rr_ptr_d = grant_v ? chwidth'((32'(grant_ch) + 32'(1)) % 32'(channels)) : rr_ptr_q;
  end

  // Per-channel pointer/occupancy update and registered full flags
  always_comb begin
    for (int c = 0; c < channels; c++) begin
      wptr_d[c]  = wptr_q[c] + ((wr_en && (32'(wch) == 32'(c))) ? ptr_one : '0);
      rptr_d[c]  = rptr_q[c] + ((grant_v && (32'(grant_ch) == 32'(c))) ? ptr_one : '0);
      count_d[c] = count_q[c];
      if ((wr_en && (32'(wch) == 32'(c))) && !(grant_v && (32'(grant_ch) == 32'(c))))
        count_d[c] = count_q[c] + cnt_one;
      else if (!(wr_en && (32'(wch) == 32'(c))) && (grant_v && (32'(grant_ch) == 32'(c))))
        count_d[c] = count_q[c] - cnt_one;
      wfull_d[c]  = (count_d[c] == cnt_full);
      wafull_d[c] = (32'(cnt_full - count_d[c]) <= 32'(almost_full_count));
    end
  end

  // Pipeline advance: S1 holds during a stall, S2 loads when free or acked
  always_comb begin
    s1_v_d  = s1_ready ? grant_v : s1_v_q;
    s1_ch_d = s1_ready ? grant_ch : s1_ch_q;
    rval_d  = s2_ready ? s1_v_q : rval_q;
    rdata_d = (s2_ready && s1_v_q) ? s1_data_q : rdata_q;
    rch_d   = (s2_ready && s1_v_q) ? s1_ch_q : rch_q;
  end

  // RAM write port and clock-enabled read register (not reset)
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[waddr] <= wdata;
    if (s1_ready)
      s1_data_q <= mem[raddr];
  end

  // Control state with synchronous reset discarding all queued data
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < channels; c++) begin
        count_q[c] <= '0;
        wptr_q[c]  <= '0;
        rptr_q[c]  <= '0;
      end
      wfull_q  <= '0;
      wafull_q <= {channels{af_reset}};
      werr_q   <= 1'b0;
      rr_ptr_q <= '0;
      s1_v_q   <= 1'b0;
      s1_ch_q  <= '0;
      rval_q   <= 1'b0;
      rdata_q  <= '0;
      rch_q    <= '0;
    end else begin
      count_q  <= count_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      werr_q   <= werr_d;
      rr_ptr_q <= rr_ptr_d;
      s1_v_q   <= s1_v_d;
      s1_ch_q  <= s1_ch_d;
      rval_q   <= rval_d;
      rdata_q  <= rdata_d;
      rch_q    <= rch_d;
    end
  end

  for (genvar gc = 0; gc < channels; gc++) begin : g_count
    assign count[gc*(awidth+1) +: awidth+1] = count_q[gc];
  end

  assign wfull  = wfull_q;
  assign wafull = wafull_q;
  assign werr   = werr_q;
  assign rval   = rval_q;
  assign rdata  = rdata_q;
  assign rch    = rch_q;

endmodule

// File: tb/tb_nvme_mc_fifo.sv
// Testbench for nvme_mc_fifo: directed scenarios plus a randomized
// scoreboard run over four channels.
module tb_nvme_mc_fifo;
  localparam int W     = 8;
  localparam int AW    = 4;
  localparam int CH    = 4;
  localparam int CHW   = 2;
  localparam int AF    = 2;
  localparam int DEPTH = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic                write;
  logic [CHW-1:0]      wch;
  logic [W-1:0]        wdata;
  logic [CH-1:0]       wfull;
  logic [CH-1:0]       wafull;
  logic                werr;
  logic [CH*(AW+1)-1:0] count;
  logic                rack;
  logic                rval;
  logic [W-1:0]        rdata;
  logic [CHW-1:0]      rch;

  int errors = 0;
  int checks = 0;

  // Reference model: expected word queues and words written-but-not-delivered
  logic [W-1:0] exp_q [CH][$];
  int           outstanding [CH];

  nvme_mc_fifo #(
    .width(W), .awidth(AW), .channels(CH), .chwidth(CHW), .almost_full_count(AF)
  ) dut (
    .clk(clk), .reset(reset), .write(write), .wch(wch), .wdata(wdata),
    .wfull(wfull), .wafull(wafull), .werr(werr), .count(count),
    .rack(rack), .rval(rval), .rdata(rdata), .rch(rch)
  );

  always #5 clk = ~clk;

  function automatic int cnt(input int c);
    return int'(count[c*(AW+1) +: AW+1]);
  endfunction

  function automatic int total_outstanding();
    int t = 0;
    for (int c = 0; c < CH; c++) t += outstanding[c];
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; write = 1'b0; wch = '0; wdata = '0; rack = 1'b0;
    step(); step();
    checks++; if (rval !== 1'b0) begin errors++; $display("[TB] FAIL rst_rval: got %0b expected 0", rval); end
    checks++; if (rdata !== '0) begin errors++; $display("[TB] FAIL rst_rdata: got %0h expected 0", rdata); end
    checks++; if (rch !== '0) begin errors++; $display("[TB] FAIL rst_rch: got %0d expected 0", rch); end
    checks++; if (werr !== 1'b0) begin errors++; $display("[TB] FAIL rst_werr: got %0b expected 0", werr); end
    checks++; if (wfull !== '0) begin errors++; $display("[TB] FAIL rst_wfull: got %0h expected 0", wfull); end
    checks++; if (wafull !== {CH{AF >= DEPTH}}) begin errors++; $display("[TB] FAIL rst_wafull: got %0h expected %0h", wafull, {CH{AF >= DEPTH}}); end
    checks++; if (count !== '0) begin errors++; $display("[TB] FAIL rst_count: got %0h expected 0", count); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_latency();
    rack = 1'b1; wch = 0; wdata = 8'h11; write = 1'b1;
    step();
    write = 1'b0;
    checks++; if (rval !== 1'b0 || cnt(0) != 1) begin errors++; $display("[TB] FAIL lat_c1: got rval=%0b count0=%0d expected rval=0 count0=1", rval, cnt(0)); end
    step();
    checks++; if (rval !== 1'b0 || cnt(0) != 0) begin errors++; $display("[TB] FAIL lat_c2: got rval=%0b count0=%0d expected rval=0 count0=0", rval, cnt(0)); end
    step();
    checks++; if (rval !== 1'b1 || rdata !== 8'h11 || rch !== 0) begin errors++; $display("[TB] FAIL lat_c3: got rval=%0b rdata=%0h rch=%0d expected 1 11 0", rval, rdata, rch); end
    step();
    checks++; if (rval !== 1'b0) begin errors++; $display("[TB] FAIL lat_c4: got rval=%0b expected 0", rval); end
  endtask

  task automatic test_full();
    logic [W-1:0] ev [18];
    int           ec [18];
    int           got;
    logic         extra;
    rack = 1'b0;
    // two ch0 words park in the output pipeline so nothing more is drained
    for (int i = 0; i < 2; i++) begin
      ev[i] = W'($urandom); ec[i] = 0;
      wch = 0; wdata = ev[i]; write = 1'b1; step();
    end
    write = 1'b0;
    repeat (4) step();
    checks++; if (rval !== 1'b1 || cnt(0) != 0) begin errors++; $display("[TB] FAIL full_park: got rval=%0b count0=%0d expected 1 0", rval, cnt(0)); end
    for (int k = 1; k <= DEPTH; k++) begin
      ev[k+1] = W'($urandom); ec[k+1] = 1;
      wch = 1; wdata = ev[k+1]; write = 1'b1;
      step();
      checks++; if (cnt(1) != k) begin errors++; $display("[TB] FAIL full_count%0d: got %0d expected %0d", k, cnt(1), k); end
      checks++; if (wfull[1] !== (k == DEPTH)) begin errors++; $display("[TB] FAIL full_wfull%0d: got %0b expected %0b", k, wfull[1], k == DEPTH); end
      checks++; if (wafull[1] !== ((DEPTH - k) <= AF)) begin errors++; $display("[TB] FAIL full_wafull%0d: got %0b expected %0b", k, wafull[1], (DEPTH - k) <= AF); end
      checks++; if (werr !== 1'b0) begin errors++; $display("[TB] FAIL full_werr%0d: got %0b expected 0", k, werr); end
    end
    wch = 1; wdata = 8'hEE; write = 1'b1;
    step();
    write = 1'b0;
    checks++; if (werr !== 1'b1 || cnt(1) != DEPTH || wfull[1] !== 1'b1) begin errors++; $display("[TB] FAIL full_drop: got werr=%0b count1=%0d wfull1=%0b expected 1 16 1", werr, cnt(1), wfull[1]); end
    step();
    checks++; if (werr !== 1'b0 || cnt(1) != DEPTH) begin errors++; $display("[TB] FAIL full_drop_after: got werr=%0b count1=%0d expected 0 16", werr, cnt(1)); end
    rack = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 80 && got < 18; cyc++) begin
      if (rval === 1'b1) begin
        checks++; if (rdata !== ev[got] || int'(rch) != ec[got]) begin errors++; $display("[TB] FAIL full_drain%0d: got %0h/ch%0d expected %0h/ch%0d", got, rdata, rch, ev[got], ec[got]); end
        got++;
      end
      step();
    end
    checks++; if (got != 18) begin errors++; $display("[TB] FAIL full_drain_timeout: got %0d words expected 18", got); end
    extra = 1'b0;
    repeat (4) begin
      if (rval !== 1'b0) extra = 1'b1;
      step();
    end
    checks++; if (extra !== 1'b0 || count !== '0) begin errors++; $display("[TB] FAIL full_no_extra: got extra=%0b count=%0h expected 0 0", extra, count); end
  endtask

  task automatic test_round_robin();
    logic [W-1:0] ev [7];
    int           ec [7];
    int           order [7] = '{2, 2, 0, 1, 0, 1, 0};
    logic [W-1:0] a [3];
    logic [W-1:0] b [2];
    logic [W-1:0] x [2];
    rack = 1'b0;
    for (int i = 0; i < 2; i++) begin x[i] = W'($urandom); wch = 2; wdata = x[i]; write = 1'b1; step(); end
    write = 1'b0;
    repeat (4) step();
    for (int i = 0; i < 3; i++) begin a[i] = W'($urandom); wch = 0; wdata = a[i]; write = 1'b1; step(); end
    for (int i = 0; i < 2; i++) begin b[i] = W'($urandom); wch = 1; wdata = b[i]; write = 1'b1; step(); end
    write = 1'b0;
    checks++; if (cnt(0) != 3 || cnt(1) != 2) begin errors++; $display("[TB] FAIL rr_load: got %0d/%0d expected 3/2", cnt(0), cnt(1)); end
    // after two ch2 grants the pointer sits at ch3, so ch0 is served first
    ev = '{x[0], x[1], a[0], b[0], a[1], b[1], a[2]};
    for (int i = 0; i < 7; i++) ec[i] = order[i];
    rack = 1'b1;
    for (int i = 0; i < 7; i++) begin
      checks++; if (rval !== 1'b1 || rdata !== ev[i] || int'(rch) != ec[i]) begin errors++; $display("[TB] FAIL rr_word%0d: got v=%0b %0h/ch%0d expected v=1 %0h/ch%0d", i, rval, rdata, rch, ev[i], ec[i]); end
      step();
    end
    checks++; if (rval !== 1'b0) begin errors++; $display("[TB] FAIL rr_end: got rval=%0b expected 0", rval); end
  endtask

  task automatic test_stall();
    logic [W-1:0] hd;
    logic [CHW-1:0] hc;
    logic [W-1:0] d;
    rack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      d = W'($urandom); exp_q[0].push_back(d); outstanding[0]++;
      wch = 0; wdata = d; write = 1'b1; step();
    end
    write = 1'b0;
    for (int cyc = 0; cyc < 10 && rval !== 1'b1; cyc++) step();
    checks++; if (rval !== 1'b1 || rdata !== exp_q[0][0] || rch !== 0) begin errors++; $display("[TB] FAIL stall_head: got v=%0b %0h/ch%0d expected v=1 %0h/ch0", rval, rdata, rch, exp_q[0][0]); end
    hd = rdata; hc = rch;
    for (int i = 0; i < 5; i++) begin
      d = W'($urandom); exp_q[1].push_back(d); outstanding[1]++;
      wch = 1; wdata = d; write = 1'b1;
      step();
      checks++; if (rval !== 1'b1 || rdata !== hd || rch !== hc) begin errors++; $display("[TB] FAIL stall_hold%0d: got v=%0b %0h/ch%0d expected v=1 %0h/ch%0d", i, rval, rdata, rch, hd, hc); end
    end
    write = 1'b0;
  endtask

  task automatic test_random();
    logic           prev_stall;
    logic [W-1:0]   prev_d;
    logic [CHW-1:0] prev_c;
    logic           rack_v;
    logic           do_w;
    logic           bad;
    int             ch;
    logic [W-1:0]   e;
    logic [W-1:0]   d;
    prev_stall = (rval === 1'b1) && !rack;
    prev_d = rdata; prev_c = rch;
    for (int it = 0; it < 1000; it++) begin
      if (prev_stall) begin
        checks++; if (rval !== 1'b1 || rdata !== prev_d || rch !== prev_c) begin errors++; $display("[TB] FAIL rnd_hold%0d: got v=%0b %0h/ch%0d expected v=1 %0h/ch%0d", it, rval, rdata, rch, prev_d, prev_c); end
      end
      bad = 1'b0;
      for (int c = 0; c < CH; c++)
        if (cnt(c) > outstanding[c] || outstanding[c] - cnt(c) > 2) bad = 1'b1;
      checks++; if (bad || werr !== 1'b0) begin errors++; $display("[TB] FAIL rnd_occ%0d: got count=%0h werr=%0b expected occupancy within 2 of %0d/%0d/%0d/%0d, werr=0", it, count, werr, outstanding[0], outstanding[1], outstanding[2], outstanding[3]); end
      rack_v = ($urandom_range(0, 3) != 0);
      ch     = int'($urandom_range(0, CH - 1));
      do_w   = ($urandom_range(0, 1) == 1) && (outstanding[ch] < DEPTH);
      if (rval === 1'b1 && rack_v) begin
        checks++;
        if (exp_q[rch].size() == 0) begin
          errors++; $display("[TB] FAIL rnd_spurious%0d: got %0h/ch%0d expected no word", it, rdata, rch);
        end else begin
          e = exp_q[rch].pop_front();
          outstanding[rch]--;
          if (rdata !== e) begin errors++; $display("[TB] FAIL rnd_data%0d: got %0h/ch%0d expected %0h", it, rdata, rch, e); end
        end
      end
      d = W'($urandom);
      if (do_w) begin exp_q[ch].push_back(d); outstanding[ch]++; end
      rack = rack_v; write = do_w; wch = CHW'(ch); wdata = d;
      prev_stall = (rval === 1'b1) && !rack_v;
      prev_d = rdata; prev_c = rch;
      step();
    end
    write = 1'b0; rack = 1'b1;
    for (int cyc = 0; cyc < 300 && total_outstanding() > 0; cyc++) begin
      if (rval === 1'b1) begin
        checks++;
        if (exp_q[rch].size() == 0) begin
          errors++; $display("[TB] FAIL rnd_drain_spurious: got %0h/ch%0d expected no word", rdata, rch);
        end else begin
          e = exp_q[rch].pop_front();
          outstanding[rch]--;
          if (rdata !== e) begin errors++; $display("[TB] FAIL rnd_drain_data: got %0h/ch%0d expected %0h", rdata, rch, e); end
        end
      end
      step();
    end
    checks++; if (total_outstanding() != 0 || count !== '0) begin errors++; $display("[TB] FAIL rnd_drain_end: got %0d undelivered count=%0h expected 0 0", total_outstanding(), count); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] d;
    rack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wch = (i < 3) ? 0 : 1; wdata = W'($urandom); write = 1'b1; step();
    end
    write = 1'b0;
    step(); step();
    checks++; if (rval !== 1'b1) begin errors++; $display("[TB] FAIL rmid_pre: got rval=%0b expected 1", rval); end
    reset = 1'b1;
    step();
    checks++; if (rval !== 1'b0 || count !== '0 || wfull !== '0) begin errors++; $display("[TB] FAIL rmid_clear: got rval=%0b count=%0h wfull=%0h expected 0 0 0", rval, count, wfull); end
    reset = 1'b0;
    for (int c = 0; c < CH; c++) begin exp_q[c].delete(); outstanding[c] = 0; end
    d = W'($urandom);
    wch = 1; wdata = d; write = 1'b1;
    step();
    write = 1'b0;
    checks++; if (rval !== 1'b0) begin errors++; $display("[TB] FAIL rmid_c1: got rval=%0b expected 0", rval); end
    step();
    checks++; if (rval !== 1'b0) begin errors++; $display("[TB] FAIL rmid_c2: got rval=%0b expected 0", rval); end
    step();
    checks++; if (rval !== 1'b1 || rdata !== d || rch !== 1) begin errors++; $display("[TB] FAIL rmid_c3: got v=%0b %0h/ch%0d expected v=1 %0h/ch1", rval, rdata, rch, d); end
    rack = 1'b1;
    step();
    checks++; if (rval !== 1'b0 || count !== '0) begin errors++; $display("[TB] FAIL rmid_end: got rval=%0b count=%0h expected 0 0", rval, count); end
  endtask

  // Scenario sequence
  initial begin
    for (int c = 0; c < CH; c++) outstanding[c] = 0;
    test_reset();
    test_latency();
    test_full();
    test_round_robin();
    test_stall();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Bound on total run time
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion expected finish before timeout");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/nvme_mc_fifo.md
Name: nvme_mc_fifo

Overview:
Single-clock, multi-channel FIFO. N independent logical queues share one inferred block RAM, with each channel owning a 2^awidth-entry region. A round-robin arbiter drains non-empty channels into a registered rval/rack output stage that tags each word with its channel number. It is used wherever several NVMe submission/completion streams feed one consumer in a single clock domain, replacing per-stream FIFO instances.

Parameters:
width, 8, data width in bits
awidth, 4, per-channel address width; each channel holds 2^awidth entries
channels, 2, number of logical channels (>=2)
chwidth, 1, channel index width; must equal ceil(log2(channels))
almost_full_count, 0, wafull[c] asserts when free entries of channel c <= this value; 0 makes wafull identical to wfull

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
write  in  1  write strobe
wch  in  chwidth  target channel of write
wdata  in  width  write data
wfull  out  channels  per-channel full, registered
wafull  out  channels  per-channel almost full, registered
werr  out  1  one-cycle pulse: write to a full channel was dropped
count  out  channels*(awidth+1)  per-channel occupancy; channel c at bits [c*(awidth+1) +: awidth+1]
rack  in  1  consumer accepts current rdata
rval  out  1  rdata/rch valid
rdata  out  width  read data
rch  out  chwidth  channel the rdata came from

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: all counts 0, wfull=0, wafull=(almost_full_count>=2^awidth), werr=0, rval=0, rdata=0, rch=0. All read/write pointers are 0 and the round-robin pointer is 0. RAM contents are not reset.
- Reset asserted mid-operation: in-flight and buffered data are discarded and rval drops on the next edge.
- Per channel c: a write pointer and a read pointer (awidth bits, wrapping at 2^awidth) and count[c] (awidth+1 bits, 0..2^awidth). RAM address = {c, ptr}.
- Write path:
  - If write & ~wfull[wch], wdata is stored at {wch, wptr[wch]}, wptr increments, and count increments.
  - If write & wfull[wch], data is dropped and werr=1 in the next cycle. No state changes.
  - wch >= channels is treated as a drop with werr.
- wfull[c] = (count[c]==2^awidth), registered from next-state count.
- wafull[c] = (2^awidth - count[c]) <= almost_full_count, registered from next-state count.
- Read pipeline, three stages:
  - S0 arbitration: eligible = count[c]!=0. If S1 is ready, grant the first eligible channel at or after rr_ptr, modulo channels. On a grant, rptr[g] increments, count[g] decrements, and rr_ptr becomes g+1 (wrapping). S0 issues a RAM read of {g, rptr[g]}.
  - S1: RAM read register with clock enable = s1_ready, so the word is held during a stall without re-reading. s1_ready = ~s1_v | s2_ready. S1 carries the channel tag.
  - S2: output register. s2_ready = ~rval | rack. It loads from S1 when s2_ready & s1_v. rval clears on rack when S1 is empty.
- Latency: a write in cycle 0 to an empty channel (pipeline idle) gives rval=1 in cycle 3. With rack held high, throughput is one word per clock.
- Handshake:
  - rdata and rch stay stable while rval & ~rack.
  - rack while rval=0 is ignored.
- Simultaneous write and grant on the same channel: count is unchanged. A full channel still drops the write because wfull is the registered value.
- A slot is free once S0 issues its read, so the writer may overwrite it from the next cycle. S1 has already captured the data at that point.
- Ordering: strict FIFO order within a channel. Between channels, round-robin order with no starvation.

Test Plan:
- Reset, then write 0x11 to ch0 in cycle 0 with rack=1 -> rval=1, rdata=0x11, rch=0 in cycle 3; count0 returns to 0.
- awidth=4: 16 writes to ch1 with no rack -> wfull[1]=1 after the 16th write. A 17th write (0xEE) -> werr pulses, count1 stays 16, and 0xEE is never read.
- almost_full_count=2: write 14 entries to ch0 -> wafull[0]=1 in the cycle after the 14th write; wafull[0]=0 after 13.
- Ch0 loaded with A0,A1,A2 and ch1 with B0,B1; rack=1 -> output order A0,B0,A1,B1,A2, back-to-back with no bubbles.
- rval=1 with rack held low for 5 cycles while writes continue -> rdata/rch stable. Releasing rack gives in-order delivery with no loss or duplication (scoreboard over 1000 random writes/racks, 4 channels).
- Assert reset for one cycle with data queued in both channels and rval=1 -> next cycle rval=0, all counts 0, wfull=0. A subsequent write to ch1 reaches the output after 3 cycles.
